// File: rtl/jtkicker_dwnld_remap.sv
// ROM-download front end: classifies ioctl bytes by region, swizzles tile-plane addresses and
// queues SDRAM byte writes in a FIFO. Optional checksum enabled by JTKICKER_DWNLD_CHKSUM_EN.
module jtkicker_dwnld_remap #(
  parameter logic [21:0]  SCR_START  = 22'h0,
  parameter logic [21:0]  OBJ_START  = 22'h0,
  parameter logic [21:0]  PCM_START  = 22'h0,
  parameter logic [24:0]  PROM_START = 25'h0,
  parameter logic [1:0]   SCR_SWZ    = 2'd1,
  parameter logic [1:0]   OBJ_SWZ    = 2'd2,
  parameter logic [24:0]  VAR_OFS    = 25'h1,
  parameter logic [7:0]   VAR_VAL    = 8'hFF,
  parameter int unsigned  DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        downloading_i,
  input  logic [24:0] ioctl_addr_i,
  input  logic [7:0]  ioctl_dout_i,
  input  logic        ioctl_wr_i,
  output logic [21:0] prog_addr_o,
  output logic [7:0]  prog_data_o,
  output logic [1:0]  prog_mask_o,
  output logic        prog_we_o,
  input  logic        sdram_ack_i,
  output logic [10:0] prom_addr_o,
  output logic [7:0]  prom_data_o,
  output logic        prom_we_o,
  output logic        variant_o,
  output logic        dwnld_busy_o,
  output logic        overflow_o,
  output logic [15:0] chksum_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);
  localparam logic [24:0]   VarAddr  = PROM_START + VAR_OFS;

  function automatic logic [21:0] swizzle(input logic [21:0] w, input logic [1:0] mode);
    logic [21:0] r;
    r = w;
    case (mode)
      2'd1:    r[3:0] = {w[2:0], ~w[3]};
      2'd2:    r[4:0] = {w[2:0], ~w[4], ~w[3]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Region boundaries via borrow bit of an extended subtraction.
  logic [25:0] prom_diff;
  logic [22:0] pcm_diff, obj_diff, scr_diff;
  logic        is_prom, in_pcm, in_obj, in_scr;
  logic        unused_diff;

  assign prom_diff   = {1'b0, ioctl_addr_i} - {1'b0, PROM_START};
  assign pcm_diff    = {1'b0, ioctl_addr_i[21:0]} - {1'b0, PCM_START};
  assign obj_diff    = {1'b0, ioctl_addr_i[21:0]} - {1'b0, OBJ_START};
  assign scr_diff    = {1'b0, ioctl_addr_i[21:0]} - {1'b0, SCR_START};
  assign is_prom     = ~prom_diff[25];
  assign in_pcm      = ~pcm_diff[22];
  assign in_obj      = ~obj_diff[22];
  assign in_scr      = ~scr_diff[22];
  assign unused_diff = ^{prom_diff[24:11], pcm_diff[21:0], obj_diff[21:0], scr_diff[21:0]};

  logic [1:0]  swz_mode;
  logic [31:0] entry;

  always_comb begin
    swz_mode = 2'd0;
    if (!in_pcm && in_obj) begin
      swz_mode = OBJ_SWZ;
    end else if (!in_pcm && in_scr) begin
      swz_mode = SCR_SWZ;
    end
    entry = {swizzle(ioctl_addr_i[22:1], swz_mode), ioctl_dout_i,
             ioctl_addr_i[0] ? 2'b01 : 2'b10};
  end

  logic dl_q, dl_rise;
  logic push_req, prom_wr, pop, full, push, drop;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign dl_rise  = downloading_i & ~dl_q;
  assign push_req = downloading_i & ioctl_wr_i & ~is_prom;
  assign prom_wr  = downloading_i & ioctl_wr_i & is_prom;
  assign pop      = sdram_ack_i & (cnt_q != '0);
  assign full     = (cnt_q == FullCnt);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dl_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      dl_q  <= downloading_i;
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  logic [31:0] head;
  assign head         = mem_q[rd_ptr_q];
  assign prog_we_o    = (cnt_q != '0);
  assign prog_addr_o  = prog_we_o ? head[31:10] : 22'h0;
  assign prog_data_o  = prog_we_o ? head[9:2]   : 8'h0;
  assign prog_mask_o  = prog_we_o ? head[1:0]   : 2'b00;
  assign dwnld_busy_o = downloading_i | prog_we_o;

  logic        overflow_q, overflow_d;
  logic        variant_q, variant_d;
  logic        prom_we_q;
  logic [10:0] prom_addr_q;
  logic [7:0]  prom_data_q;

  always_comb begin
    overflow_d = (overflow_q & ~dl_rise) | drop;
    variant_d  = variant_q & ~dl_rise;
    if (prom_wr && ioctl_addr_i == VarAddr) begin
      variant_d = (ioctl_dout_i == VAR_VAL);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      variant_q   <= 1'b0;
      prom_we_q   <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      variant_q  <= variant_d;
      prom_we_q  <= prom_wr;
      if (prom_wr) begin
        prom_addr_q <= prom_diff[10:0];
        prom_data_q <= ioctl_dout_i;
      end
    end
  end

  assign overflow_o  = overflow_q;
  assign variant_o   = variant_q;
  assign prom_we_o   = prom_we_q;
  assign prom_addr_o = prom_addr_q;
  assign prom_data_o = prom_data_q;

`ifdef JTKICKER_DWNLD_CHKSUM_EN
  logic [15:0] chksum_q, chksum_d;

  always_comb begin
    chksum_d = dl_rise ? 16'h0 : chksum_q;
    if (push) chksum_d = chksum_d + {8'h00, ioctl_dout_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chksum_q <= 16'h0;
    end else begin
      chksum_q <= chksum_d;
    end
  end

  assign chksum_o = chksum_q;
`else
  assign chksum_o = 16'h0;
`endif

endmodule
